// File: rtl/jerry_ctl.sv
// Jerry sprite movement controller: once per frame (vblnk rising edge) applies
// walking, jump launch, rise and gravity fall, and publishes registered coordinates.
module jerry_ctl #(
  parameter int X_INIT   = 100,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 760,
  parameter int Y_MIN    = 0,
  parameter int GROUND_Y = 500,
  parameter int SPEED_X  = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vblnk,
  input  logic       freeze,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump,
  output logic [9:0] jerry_x,
  output logic [9:0] jerry_y,
  output logic       airborne,
  output logic       frame_tick,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } state_t;

  localparam logic [10:0] X_INIT_W   = 11'(X_INIT);
  localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
  localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_W    = 11'(Y_MIN);
  localparam logic [10:0] GROUND_Y_W = 11'(GROUND_Y);
  localparam logic [10:0] SPEED_X_W  = 11'(SPEED_X);
  localparam logic [7:0]  JUMP_V_W   = 8'(JUMP_V);
  localparam logic [8:0]  GRAVITY_W  = 9'(GRAVITY);
  localparam logic [8:0]  V_MAX_W    = 9'(V_MAX);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  vy_q, vy_d;
  logic        armed_q, armed_d;
  logic        vblnk_q;
  logic        airborne_q;
  logic        frame_tick_q;
  logic        tick;

  // All position arithmetic is 11 bits wide so nothing wraps near the edges.
  logic [10:0] x_ext, y_ext, vy_ext;
  logic [10:0] x_add, x_sub, y_up, y_down;
  logic [8:0]  vy_inc, vy_dec;

  assign tick   = vblnk & ~vblnk_q & ~freeze;
  assign x_ext  = {1'b0, x_q};
  assign y_ext  = {1'b0, y_q};
  assign vy_ext = {3'b000, vy_q};
  assign x_add  = x_ext + SPEED_X_W;
  assign x_sub  = x_ext - SPEED_X_W;
  assign y_up   = y_ext - vy_ext;
  assign y_down = y_ext + vy_ext;
  assign vy_inc = {1'b0, vy_q} + GRAVITY_W;
  assign vy_dec = ({1'b0, vy_q} > GRAVITY_W) ? ({1'b0, vy_q} - GRAVITY_W) : 9'd0;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    armed_d = armed_q;
    if (tick) begin
      if (!jump) armed_d = 1'b1;

      if (move_left && !move_right) begin
        if (x_ext < X_MIN_W + SPEED_X_W) x_d = X_MIN_W[9:0];
        else                             x_d = x_sub[9:0];
      end else if (move_right && !move_left) begin
        if (x_add > X_MAX_W) x_d = X_MAX_W[9:0];
        else                 x_d = x_add[9:0];
      end

      case (state_q)
        ST_GROUND: begin
          if (jump && armed_q) begin
            state_d = ST_RISE;
            vy_d    = JUMP_V_W;
            armed_d = 1'b0;
          end else begin
            y_d  = GROUND_Y_W[9:0];
            vy_d = 8'd0;
          end
        end
        ST_RISE: begin
          if (y_ext < vy_ext + Y_MIN_W) begin
            y_d     = Y_MIN_W[9:0];
            vy_d    = 8'd0;
            state_d = ST_FALL;
          end else begin
            y_d  = y_up[9:0];
            vy_d = vy_dec[7:0];
            if (vy_dec == 9'd0) state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (y_down >= GROUND_Y_W) begin
            y_d     = GROUND_Y_W[9:0];
            vy_d    = 8'd0;
            state_d = ST_GROUND;
          end else begin
            y_d  = y_down[9:0];
            vy_d = (vy_inc > V_MAX_W) ? V_MAX_W[7:0] : vy_inc[7:0];
          end
        end
        default: begin
          state_d = ST_GROUND;
          y_d     = GROUND_Y_W[9:0];
          vy_d    = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GROUND;
      x_q          <= X_INIT_W[9:0];
      y_q          <= GROUND_Y_W[9:0];
      vy_q         <= 8'd0;
      armed_q      <= 1'b1;
      vblnk_q      <= 1'b0;
      airborne_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vy_q         <= vy_d;
      armed_q      <= armed_d;
      vblnk_q      <= vblnk;
      airborne_q   <= (state_d != ST_GROUND);
      frame_tick_q <= tick;
    end
  end

  assign jerry_x    = x_q;
  assign jerry_y    = y_q;
  assign airborne   = airborne_q;
  assign frame_tick = frame_tick_q;
  assign state_dbg  = state_q;

endmodule
